mp_addsub_seq: RTL

Multi-precision add/subtract sequencer for the 32-bit ADD/ADCS/SUBS adder datapath. It streams operands of up to MAX_WORDS 32-bit words, least-significant word first, through a single adder instance. Between words it holds the carry in a register, so a 256-bit add or subtract costs one adder plus a small controller. It sits between the ALU front end, which supplies operand words, and the result writeback stream.

---
 rtl/mp_addsub_seq_pkg.sv | 8 +
 rtl/mp_addsub_seq_adder.sv | 18 +
 rtl/mp_addsub_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mp_addsub_seq_pkg.sv
// Shared ALU definitions for the multi-precision add/subtract sequencer.
package mp_addsub_seq_pkg;
  localparam int DATA_W = 32;
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;
endpackage

// File: rtl/mp_addsub_seq_adder.sv
// 32-bit ADD/ADCS/SUBS adder: subtract inverts b and forces carry-in to 1.
module ADD_ADCS_SUBS
  import mp_addsub_seq_pkg::*;
(
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] s,
  output logic              c_out
);
  logic [DATA_W-1:0] b_eff;
  logic              c_eff;

  assign b_eff = (op == ALU_OP_SUB) ? ~b : b;
  assign c_eff = (op == ALU_OP_SUB) ? 1'b1 : c_in;
  assign {c_out, s} = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, c_eff};
endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer around one 32-bit adder, LS word first.
// Optional z/v flag logic is built when MPADD_FLAGS_EN is defined.
module mp_addsub_seq
  import mp_addsub_seq_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              op,
  input  logic              c_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_word,
  input  logic [DATA_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] s_word,
  output logic              busy,
  output logic              done,
  output logic              c_out,
  output logic              z_flag,
  output logic              v_flag
);
  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_reg, cnt;
  logic              op_reg, cin_reg, carry_reg;
  logic              hs, first, last;
  logic [DATA_W-1:0] b_inv, add_b, add_s;
  logic              add_op, add_ci, add_co;

  assign hs    = in_valid && in_ready;
  assign first = (cnt == '0);
  assign last  = (cnt == len_reg - LEN_W'(1));
  assign b_inv = op_reg ? ~b_word : b_word;

  // Only word 0 uses the adder's own subtract; later words pre-invert b and chain the carry.
  assign add_op = first ? op_reg  : ALU_OP_ADD;
  assign add_b  = first ? b_word  : b_inv;
  assign add_ci = first ? cin_reg : carry_reg;

  ADD_ADCS_SUBS u_adder (
    .op   (add_op),
    .a    (a_word),
    .b    (add_b),
    .c_in (add_ci),
    .s    (add_s),
    .c_out(add_co)
  );

`ifdef MPADD_FLAGS_EN
  logic z_acc, v_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      z_acc <= 1'b0;
      v_reg <= 1'b0;
    end else if (state == IDLE && start) begin
      z_acc <= 1'b1;
      v_reg <= 1'b0;
    end else if (hs) begin
      z_acc <= z_acc & (add_s == '0);
      v_reg <= (a_word[DATA_W-1] == b_inv[DATA_W-1]) && (add_s[DATA_W-1] != a_word[DATA_W-1]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    c_out     = 1'b0;
    z_flag    = 1'b0;
    v_flag    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? FIN : RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready) && last) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (!out_valid || out_ready) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        c_out     = carry_reg;
`ifdef MPADD_FLAGS_EN
        z_flag    = z_acc;
        v_flag    = v_reg;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg   <= '0;
      op_reg    <= 1'b0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      s_word    <= '0;
    end else begin
      // Preloading the effective carry-in makes a zero-length job report it directly.
      if (state == IDLE && start) begin
        len_reg   <= len;
        op_reg    <= op;
        cin_reg   <= c_in;
        carry_reg <= op ? 1'b1 : c_in;
        cnt       <= '0;
      end
      if (hs) begin
        carry_reg <= add_co;
        cnt       <= cnt + LEN_W'(1);
        s_word    <= add_s;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
